mem_read_driver: RTL and testbench

Read-side engine of the memory driver. Consumes the 8-bit address stream produced by the address up-counter, issues reads to a synchronous single-port RAM with 1-cycle read latency, and delivers read data on a ready/valid stream. Backpressure propagates to the counter through `addr_ready`, which drives the counter's `enable`.

---
 rtl/mem_drv_pkg.sv | 15 +
 rtl/rd_skid_fifo.sv | 66 ++++++
 rtl/mem_read_driver.sv | 111 +++++++++++
 tb/tb_mem_read_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_drv_pkg.sv
// Shared types for the memory driver: address width and read-engine state encoding.
// No logic; imported by the counter, write driver and read driver.
// Not applicable: no datapath or flow control in this file.
package mem_drv_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Purpose: 2-entry FIFO holding read-return data ahead of the output stream.
// Latency: a push is visible at pop_dat the following cycle.
// Backpressure: push while full is dropped unless paired with a pop; caller keeps credit.
module rd_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign count   = cnt_q;
    assign pop_dat = rd_ptr_q ? ent1_q : ent0_q;

    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        if (do_push) begin
            if (wr_ptr_q) ent1_d = push_dat;
            else          ent0_d = push_dat;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_read_driver.sv
// Purpose: read engine; turns the counter address stream into RAM reads and a ready/valid data stream (parity check under MEM_RD_PARITY_EN).
// Latency: address accepted in cycle N gives dout_valid in N+2 when the buffer is empty.
// Backpressure: addr_ready only while buffered + in-flight words leave room, so the counter stalls on a full buffer.
module mem_read_driver
    import mem_drv_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              addr_valid,
    output logic              addr_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
`ifdef MEM_RD_PARITY_EN
    input  logic              mem_rpar,
    output logic              par_err,
`endif
    output logic              busy,
    output logic              done
);

    rd_state_t  state_q, state_d;
    logic       inflight_q, inflight_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fifo_full, fifo_empty;
    logic [1:0] fifo_cnt;
    logic       pop, credit_ok, accept;

    rd_skid_fifo #(.W(DATA_W)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat (mem_rdata),
        .pop      (pop),
        .pop_dat  (dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign dout_valid = !fifo_empty;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        pop = !fifo_empty && dout_ready;
        // A word leaving this cycle frees its slot, keeping one word per cycle at full rate.
        if (pop) credit_ok = !(fifo_full && inflight_q);
        else     credit_ok = ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < 3'd2;
        addr_ready = (state_q == RD_RUN) && credit_ok;
        accept     = addr_valid && addr_ready;
        mem_rd_en  = accept;
        mem_addr   = accept ? addr : '0;
        inflight_d = accept;

        state_d = state_q;
        case (state_q)
            RD_IDLE:  if (start) state_d = RD_RUN;
            RD_RUN:   if (accept && (addr == LAST_ADDR)) state_d = RD_DRAIN;
            RD_DRAIN: if (!inflight_q && fifo_empty) state_d = RD_DONE;
            RD_DONE:  state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
        busy_d = (state_d != RD_IDLE);
        done_d = (state_d == RD_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RD_IDLE;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef MEM_RD_PARITY_EN
    logic par_err_q, par_err_d;

    assign par_err = par_err_q;

    always_comb begin
        par_err_d = par_err_q;
        if (start && (state_q == RD_IDLE)) begin
            par_err_d = 1'b0;
        end else if (inflight_q && ((^mem_rdata) != mem_rpar)) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err_q <= 1'b0;
        else      par_err_q <= par_err_d;
    end
`endif

endmodule

// File: tb/tb_mem_read_driver.sv
// Directed bench for mem_read_driver with a counter and RAM model (data = addr + 8'h10), LAST_ADDR = 8'h03.
module tb_mem_read_driver;

    localparam logic [7:0] LAST = 8'h03;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] addr;
    logic       addr_valid, addr_ready;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] dout;
    logic       dout_valid, dout_ready;
    logic       busy, done;
`ifdef MEM_RD_PARITY_EN
    logic       mem_rpar = 1'b0;
    logic       par_err;
    logic       corrupt;
`endif

    int checks   = 0;
    int failures = 0;

    mem_read_driver #(.DATA_W(8), .LAST_ADDR(LAST)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef MEM_RD_PARITY_EN
        .mem_rpar   (mem_rpar),
        .par_err    (par_err),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Counter and RAM models
    logic [7:0] caddr = 8'h00;
    logic       cnt_clr, cnt_en;
    assign addr       = caddr;
    assign addr_valid = cnt_en && (caddr <= LAST);

    always @(posedge clk) begin
        if (cnt_clr) caddr <= 8'h00;
        else if (addr_valid && addr_ready) caddr <= caddr + 8'h01;
        if (mem_rd_en) begin
            mem_rdata <= mem_addr + 8'h10;
`ifdef MEM_RD_PARITY_EN
            mem_rpar  <= (^(mem_addr + 8'h10)) ^ (corrupt && (mem_addr == 8'h02));
`endif
        end
    end

    // Monitor
    int         cyc = 0, acc_cnt = 0, out_cnt = 0, done_cnt = 0;
    int         first_acc = 0, first_out = 0, last_out = 0, max_occ = 0;
    int         acc2_cyc = 0, par_rise = 0;
    logic [7:0] got[$];
    logic       mon_clr;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            acc_cnt = 0; out_cnt = 0; first_acc = 0; first_out = 0; last_out = 0;
            max_occ = 0; acc2_cyc = 0; par_rise = 0;
            got.delete();
        end else if (rst) begin
            if (addr_valid && addr_ready) begin
                if (acc_cnt == 0) first_acc = cyc;
                if (addr == 8'h02) acc2_cyc = cyc;
                acc_cnt = acc_cnt + 1;
            end
            if (dout_valid && dout_ready) begin
                if (out_cnt == 0) first_out = cyc;
                last_out = cyc;
                out_cnt  = out_cnt + 1;
                got.push_back(dout);
            end
            if (done) done_cnt = done_cnt + 1;
            if (acc_cnt - out_cnt > max_occ) max_occ = acc_cnt - out_cnt;
`ifdef MEM_RD_PARITY_EN
            if (par_err && par_rise == 0) par_rise = cyc;
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        cnt_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, input bit toggle);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            if (toggle) dout_ready = ~dout_ready;
            n = n + 1;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_seq(input string tag);
        logic [31:0] v;
        chk({tag, "_len"}, got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            v = (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD_BEEF;
            chk($sformatf("%s_w%0d", tag, i), v, 32'h10 + i);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cnt_en = 1'b0; dout_ready = 1'b0;
        cnt_clr = 1'b0; mon_clr = 1'b0;
`ifdef MEM_RD_PARITY_EN
        corrupt = 1'b0;
`endif
        tick(); tick();
        chk("rst_addr_ready", {31'd0, addr_ready}, 32'd0);
        chk("rst_mem_rd_en",  {31'd0, mem_rd_en},  32'd0);
        chk("rst_mem_addr",   {24'd0, mem_addr},   32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout",       {24'd0, dout},       32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
`ifdef MEM_RD_PARITY_EN
        chk("rst_par_err",    {31'd0, par_err},    32'd0);
`endif
        rst = 1'b1;
        tick();
        clear_mon();

        // Basic pass at full rate
        dout_ready = 1'b1;
        cnt_en     = 1'b1;
        pulse_start();
        chk("t1_busy_run", {31'd0, busy}, 32'd1);
        wait_done("t1_done_seen", 40, 1'b0);
        chk("t1_busy_in_done", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_done_once", done_cnt, 32'd1);
        chk("t1_done_low",  {31'd0, done}, 32'd0);
        chk("t1_busy_low",  {31'd0, busy}, 32'd0);
        check_seq("t1");
        chk("t1_latency", first_out - first_acc, 32'd2);
        chk("t1_back2back", last_out - first_out, 32'd3);
`ifdef MEM_RD_PARITY_EN
        chk("t1_par_err", {31'd0, par_err}, 32'd0);
`endif

        // Downstream stall for 5 cycles after the first word
        clear_mon();
        dout_ready = 1'b0;
        pulse_start();
        for (int n = 0; n < 20 && !dout_valid; n++) tick();
        chk("t2_first_valid", {31'd0, dout_valid}, 32'd1);
        for (int n = 0; n < 5; n++) tick();
        chk("t2_stall_ready", {31'd0, addr_ready}, 32'd0);
        chk("t2_stall_accepts", acc_cnt, 32'd2);
        chk("t2_counter_held", {24'd0, caddr}, 32'd2);
        dout_ready = 1'b1;
        wait_done("t2_done_seen", 40, 1'b0);
        tick();
        check_seq("t2");
        chk("t2_done_once", done_cnt, 32'd2);
        chk("t2_occ_le2", {31'd0, (max_occ <= 2)}, 32'd1);

        // Downstream ready toggling every cycle
        clear_mon();
        dout_ready = 1'b1;
        pulse_start();
        wait_done("t3_done_seen", 60, 1'b1);
        tick();
        dout_ready = 1'b1;
        check_seq("t3");
        chk("t3_occ_le2", {31'd0, (max_occ <= 2)}, 32'd1);
        chk("t3_done_once", done_cnt, 32'd3);

        // Reset the cycle after address 1 is accepted
        clear_mon();
        pulse_start();
        for (int n = 0; n < 20 && acc_cnt < 2; n++) tick();
        chk("t4_two_accepts", acc_cnt, 32'd2);
        chk("t4_pre_busy",  {31'd0, busy},       32'd1);
        chk("t4_pre_valid", {31'd0, dout_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t4_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("t4_rst_busy",  {31'd0, busy},       32'd0);
        chk("t4_rst_ready", {31'd0, addr_ready}, 32'd0);
        chk("t4_rst_dout",  {24'd0, dout},       32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t4_no_done", done_cnt, 32'd3);
        clear_mon();
        pulse_start();
        wait_done("t4_done_seen", 40, 1'b0);
        tick();
        check_seq("t4");
        chk("t4_done_once", done_cnt, 32'd4);

        // start pulsed mid-pass is ignored
        clear_mon();
        pulse_start();
        pulse_start();
        wait_done("t5_done_seen", 40, 1'b0);
        tick();
        check_seq("t5");
        for (int n = 0; n < 5; n++) tick();
        chk("t5_single_done", done_cnt, 32'd5);
        chk("t5_idle", {31'd0, busy}, 32'd0);

`ifdef MEM_RD_PARITY_EN
        // Corrupted parity on address 2
        clear_mon();
        corrupt = 1'b1;
        pulse_start();
        wait_done("t6_done_seen", 40, 1'b0);
        tick();
        chk("t6_par_sticky", {31'd0, par_err}, 32'd1);
        chk("t6_par_timing", par_rise - acc2_cyc, 32'd2);
        check_seq("t6");
        corrupt = 1'b0;
        clear_mon();
        pulse_start();
        chk("t6_par_cleared", {31'd0, par_err}, 32'd0);
        wait_done("t6b_done_seen", 40, 1'b0);
        tick();
        chk("t6b_par_clean", {31'd0, par_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
